axi4_stream_pkt_arbiter: RTL and testbench

// - Packet-granular round-robin arbiter. Merges N AXI4-Stream sources into one sink.
// - Sources are normally the pkt_o sides of per-channel packet FIFOs. Such a FIFO raises

---
 rtl/axi4_stream_pkg.sv | 24 ++
 rtl/axi4_stream_if.sv | 27 ++
 rtl/rr_pick.sv | 32 +++
 rtl/axi4_stream_pkt_arbiter.sv | 119 +++++++++++
 tb/tb_axi4_stream_pkt_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_stream_pkg.sv
// Shared AXI4-Stream types: the word record carried on a stream and the arbiter state set.
package axi4_stream_pkg;

   localparam int AXIS_DATA_WIDTH = 32;
   localparam int AXIS_USER_WIDTH = 1;
   localparam int AXIS_DEST_WIDTH = 1;
   localparam int AXIS_ID_WIDTH   = 1;

   typedef struct packed {
      logic [AXIS_DATA_WIDTH-1:0]   tdata;
      logic [AXIS_DATA_WIDTH/8-1:0] tstrb;
      logic [AXIS_DATA_WIDTH/8-1:0] tkeep;
      logic                         tlast;
      logic [AXIS_USER_WIDTH-1:0]   tuser;
      logic [AXIS_DEST_WIDTH-1:0]   tdest;
      logic [AXIS_ID_WIDTH-1:0]     tid;
   } axi4_stream_word_t;

   typedef enum logic {
      IDLE = 1'b0,
      PASS = 1'b1
   } arb_state_t;

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle; master drives payload and tvalid, slave drives tready.
interface axi4_stream_if #(
   parameter int DATA_WIDTH = 32,
   parameter int USER_WIDTH = 1,
   parameter int DEST_WIDTH = 1,
   parameter int ID_WIDTH   = 1
);
   logic [DATA_WIDTH-1:0]   tdata;
   logic [DATA_WIDTH/8-1:0] tstrb;
   logic [DATA_WIDTH/8-1:0] tkeep;
   logic                    tlast;
   logic [USER_WIDTH-1:0]   tuser;
   logic [DEST_WIDTH-1:0]   tdest;
   logic [ID_WIDTH-1:0]     tid;
   logic                    tvalid;
   logic                    tready;

   modport master (
      output tdata, tstrb, tkeep, tlast, tuser, tdest, tid, tvalid,
      input  tready
   );

   modport slave (
      input  tdata, tstrb, tkeep, tlast, tuser, tdest, tid, tvalid,
      output tready
   );
endinterface

// File: rtl/rr_pick.sv
// Rotating-priority finder: first set bit of req searching upward from ptr, wrapping at N.
module rr_pick #(
   parameter int N         = 4,
   parameter int SEL_WIDTH = $clog2(N)
) (
   input  logic [N-1:0]         req,
   input  logic [SEL_WIDTH-1:0] ptr,
   output logic                 valid,
   output logic [SEL_WIDTH-1:0] idx
);
   logic [SEL_WIDTH:0]   sum;
   logic [SEL_WIDTH-1:0] cand;

   // Walk distances from far to near so the nearest requester is written last and wins.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      sum   = '0;
      cand  = '0;
      for (int d = N - 1; d >= 0; d--) begin
         sum = {1'b0, ptr} + (SEL_WIDTH+1)'(d);
         if (sum >= (SEL_WIDTH+1)'(N)) begin
            sum = sum - (SEL_WIDTH+1)'(N);
         end
         cand = sum[SEL_WIDTH-1:0];
         if (req[cand]) begin
            valid = 1'b1;
            idx   = cand;
         end
      end
   end
endmodule

// File: rtl/axi4_stream_pkt_arbiter.sv
// Packet-granular round-robin arbiter merging INPUTS_AMOUNT AXI4-Stream sources onto pkt_o.
// state | meaning
// IDLE  | no owner; rotating search from rr_ptr picks the next source
// PASS  | pkt_o mirrors pkt_i[sel] until the tlast handshake
module axi4_stream_pkt_arbiter
   import axi4_stream_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int USER_WIDTH    = 1,
   parameter int DEST_WIDTH    = 1,
   parameter int ID_WIDTH      = 1,
   parameter int INPUTS_AMOUNT = 4,
   parameter int SEL_WIDTH     = $clog2(INPUTS_AMOUNT)
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   axi4_stream_if.slave             pkt_i [INPUTS_AMOUNT-1:0],
   axi4_stream_if.master            pkt_o,
   output logic [INPUTS_AMOUNT-1:0] grant_o,
   output logic                     busy_o,
   output logic                     pkt_done_o
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   arb_state_t               state_q, state_d;
   logic [SEL_WIDTH-1:0]     sel_q, sel_d;
   logic [SEL_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;
   logic [SEL_WIDTH-1:0]     sel_next;
   logic                     done_d;
   logic                     beat_last;
   logic                     pick_valid;
   logic [SEL_WIDTH-1:0]     pick_idx;

   logic [INPUTS_AMOUNT-1:0] req;
   logic [INPUTS_AMOUNT-1:0] in_tlast;
   logic [DATA_WIDTH-1:0]    in_tdata [INPUTS_AMOUNT];
   logic [STRB_WIDTH-1:0]    in_tstrb [INPUTS_AMOUNT];
   logic [STRB_WIDTH-1:0]    in_tkeep [INPUTS_AMOUNT];
   logic [USER_WIDTH-1:0]    in_tuser [INPUTS_AMOUNT];
   logic [DEST_WIDTH-1:0]    in_tdest [INPUTS_AMOUNT];
   logic [ID_WIDTH-1:0]      in_tid   [INPUTS_AMOUNT];

   assign busy_o = (state_q == PASS);

   for (genvar g = 0; g < INPUTS_AMOUNT; g++) begin : g_src
      assign req[g]          = pkt_i[g].tvalid;
      assign in_tlast[g]     = pkt_i[g].tlast;
      assign in_tdata[g]     = pkt_i[g].tdata;
      assign in_tstrb[g]     = pkt_i[g].tstrb;
      assign in_tkeep[g]     = pkt_i[g].tkeep;
      assign in_tuser[g]     = pkt_i[g].tuser;
      assign in_tdest[g]     = pkt_i[g].tdest;
      assign in_tid[g]       = pkt_i[g].tid;
      assign grant_o[g]      = busy_o && (sel_q == SEL_WIDTH'(g));
      assign pkt_i[g].tready = grant_o[g] && pkt_o.tready;
   end

   rr_pick #(
      .N         (INPUTS_AMOUNT),
      .SEL_WIDTH (SEL_WIDTH)
   ) u_rr_pick (
      .req   (req),
      .ptr   (rr_ptr_q),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   // Data fields follow sel even in IDLE; only tvalid is gated by ownership.
   always_comb begin
      pkt_o.tvalid = busy_o && req[sel_q];
      pkt_o.tlast  = in_tlast[sel_q];
      pkt_o.tdata  = in_tdata[sel_q];
      pkt_o.tstrb  = in_tstrb[sel_q];
      pkt_o.tkeep  = in_tkeep[sel_q];
      pkt_o.tuser  = in_tuser[sel_q];
      pkt_o.tdest  = in_tdest[sel_q];
      pkt_o.tid    = in_tid[sel_q];
   end

   assign beat_last = pkt_o.tvalid && pkt_o.tready && pkt_o.tlast;
   assign sel_next  = (sel_q == SEL_WIDTH'(INPUTS_AMOUNT - 1)) ? '0 : sel_q + 1'b1;

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      rr_ptr_d = rr_ptr_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               sel_d   = pick_idx;
               state_d = PASS;
            end
         end
         PASS: begin
            if (beat_last) begin
               done_d   = 1'b1;
               rr_ptr_d = sel_next;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         sel_q      <= '0;
         rr_ptr_q   <= '0;
         pkt_done_o <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         rr_ptr_q   <= rr_ptr_d;
         pkt_done_o <= done_d;
      end
   end
endmodule

// File: tb/tb_axi4_stream_pkt_arbiter.sv
// Bench for axi4_stream_pkt_arbiter: directed scenarios then random traffic on a 4-input and a 3-input instance.
module tb_axi4_stream_pkt_arbiter;
   import axi4_stream_pkg::*;

   localparam int NQ = 8;

   logic clk_i = 1'b0;
   logic rst_i;
   always #5 clk_i = ~clk_i;

   axi4_stream_if src0_if [3:0] ();
   axi4_stream_if src1_if [2:0] ();
   axi4_stream_if out0_if ();
   axi4_stream_if out1_if ();

   axi4_stream_word_t s_word [NQ];
   logic              s_valid [NQ];
   logic [3:0]        rdy0;
   logic [2:0]        rdy1;
   logic              o_ready [2];
   axi4_stream_word_t o_word0, o_word1;
   logic [3:0]        grant0;
   logic [2:0]        grant1;
   logic              busy0, busy1, done0, done1;

   for (genvar g = 0; g < 4; g++) begin : g_src0
      assign src0_if[g].tdata  = s_word[g].tdata;
      assign src0_if[g].tstrb  = s_word[g].tstrb;
      assign src0_if[g].tkeep  = s_word[g].tkeep;
      assign src0_if[g].tlast  = s_word[g].tlast;
      assign src0_if[g].tuser  = s_word[g].tuser;
      assign src0_if[g].tdest  = s_word[g].tdest;
      assign src0_if[g].tid    = s_word[g].tid;
      assign src0_if[g].tvalid = s_valid[g];
      assign rdy0[g]           = src0_if[g].tready;
   end

   for (genvar g = 0; g < 3; g++) begin : g_src1
      assign src1_if[g].tdata  = s_word[4+g].tdata;
      assign src1_if[g].tstrb  = s_word[4+g].tstrb;
      assign src1_if[g].tkeep  = s_word[4+g].tkeep;
      assign src1_if[g].tlast  = s_word[4+g].tlast;
      assign src1_if[g].tuser  = s_word[4+g].tuser;
      assign src1_if[g].tdest  = s_word[4+g].tdest;
      assign src1_if[g].tid    = s_word[4+g].tid;
      assign src1_if[g].tvalid = s_valid[4+g];
      assign rdy1[g]           = src1_if[g].tready;
   end

   assign out0_if.tready = o_ready[0];
   assign out1_if.tready = o_ready[1];
   assign o_word0 = {out0_if.tdata, out0_if.tstrb, out0_if.tkeep, out0_if.tlast,
                     out0_if.tuser, out0_if.tdest, out0_if.tid};
   assign o_word1 = {out1_if.tdata, out1_if.tstrb, out1_if.tkeep, out1_if.tlast,
                     out1_if.tuser, out1_if.tdest, out1_if.tid};

   axi4_stream_pkt_arbiter #(.INPUTS_AMOUNT(4)) u_dut0 (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .pkt_i      (src0_if),
      .pkt_o      (out0_if),
      .grant_o    (grant0),
      .busy_o     (busy0),
      .pkt_done_o (done0)
   );

   axi4_stream_pkt_arbiter #(.INPUTS_AMOUNT(3)) u_dut1 (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .pkt_i      (src1_if),
      .pkt_o      (out1_if),
      .grant_o    (grant1),
      .busy_o     (busy1),
      .pkt_done_o (done1)
   );

   // Reference model: per-unit owner/pointer plus per-source packet queues.
   axi4_stream_word_t q [NQ][$];
   int  order [2][$];
   bit  m_busy [2];
   bit  m_done [2];
   int  m_owner [2];
   int  m_ptr [2];
   int  n_src [2];
   int  beats [2];
   int  dones [2];
   bit  gap [NQ];
   bit  rand_gap;
   int  rdy_mode;
   int  cyc;
   int  n_assert;
   int  n_fail;

   function automatic logic [3:0] f_grant(input int u);
      return (u == 0) ? grant0 : {1'b0, grant1};
   endfunction
   function automatic logic [3:0] f_rdy(input int u);
      return (u == 0) ? rdy0 : {1'b0, rdy1};
   endfunction
   function automatic logic f_busy(input int u);
      return (u == 0) ? busy0 : busy1;
   endfunction
   function automatic logic f_done(input int u);
      return (u == 0) ? done0 : done1;
   endfunction
   function automatic logic f_valid(input int u);
      return (u == 0) ? out0_if.tvalid : out1_if.tvalid;
   endfunction
   function automatic axi4_stream_word_t f_word(input int u);
      return (u == 0) ? o_word0 : o_word1;
   endfunction

   function automatic int onehot_idx(input logic [3:0] g);
      int r;
      r = -1;
      for (int i = 3; i >= 0; i--) if (g[i]) r = i;
      return r;
   endfunction

   function automatic logic [63:0] order_code(input int u);
      logic [63:0] c;
      c = '0;
      for (int i = 0; i < order[u].size(); i++) c = (c << 4) | 64'((order[u][i] + 1) & 15);
      return c;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s @%0t: observed=%0h expected=%0h", tag, $time, obs, exp);
      end
   endtask

   task automatic add_pkt(input int u, input int k, input int len, input logic [31:0] d0,
                          input logic [31:0] step, input bit rnd);
      axi4_stream_word_t w;
      for (int i = 0; i < len; i++) begin
         w.tdata = rnd ? 32'($urandom) : d0 + step * 32'(i);
         w.tstrb = 4'($urandom);
         w.tkeep = 4'($urandom);
         w.tlast = (i == len - 1);
         w.tuser = 1'($urandom);
         w.tdest = 1'($urandom);
         w.tid   = 1'($urandom);
         q[u*4+k].push_back(w);
      end
   endtask

   task automatic check_unit(input int u);
      int n, own;
      logic [3:0] exp_g, exp_r;
      logic exp_v;
      axi4_stream_word_t w;
      n     = n_src[u];
      own   = m_owner[u];
      exp_g = m_busy[u] ? 4'(1 << own) : 4'h0;
      exp_v = m_busy[u] && s_valid[u*4+own];
      exp_r = (m_busy[u] && o_ready[u]) ? exp_g : 4'h0;
      chk($sformatf("u%0d grant", u), 64'(f_grant(u)), 64'(exp_g));
      chk($sformatf("u%0d busy", u), 64'(f_busy(u)), 64'(m_busy[u]));
      chk($sformatf("u%0d done", u), 64'(f_done(u)), 64'(m_done[u]));
      chk($sformatf("u%0d tvalid", u), 64'(f_valid(u)), 64'(exp_v));
      chk($sformatf("u%0d src_tready", u), 64'(f_rdy(u)), 64'(exp_r));
      if (f_done(u)) dones[u]++;
      m_done[u] = 1'b0;
      if (m_busy[u]) begin
         if (exp_v) begin
            chk($sformatf("u%0d word", u), 64'(f_word(u)), 64'(q[u*4+own][0]));
            if (o_ready[u]) begin
               w = q[u*4+own].pop_front();
               beats[u]++;
               if (w.tlast) begin
                  order[u].push_back(onehot_idx(f_grant(u)));
                  m_done[u] = 1'b1;
                  m_ptr[u]  = (own + 1) % n;
                  m_busy[u] = 1'b0;
               end
            end
         end
      end else begin
         for (int d = 0; d < n; d++) begin
            if (!m_busy[u] && s_valid[u*4 + (m_ptr[u] + d) % n]) begin
               m_owner[u] = (m_ptr[u] + d) % n;
               m_busy[u]  = 1'b1;
            end
         end
      end
   endtask

   task automatic cycle();
      for (int i = 0; i < NQ; i++) begin
         gap[i]     = rand_gap && ($urandom_range(0, 3) == 0);
         s_valid[i] = (q[i].size() != 0) && !gap[i];
         s_word[i]  = (q[i].size() != 0) ? q[i][0] : '0;
      end
      for (int u = 0; u < 2; u++) begin
         case (rdy_mode)
            0:       o_ready[u] = 1'b1;
            1:       o_ready[u] = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: o_ready[u] = ($urandom_range(0, 3) != 0);
         endcase
      end
      #1;
      check_unit(0);
      check_unit(1);
      cyc++;
      @(negedge clk_i);
   endtask

   function automatic bit pending();
      bit p;
      p = m_busy[0] || m_busy[1] || m_done[0] || m_done[1];
      for (int i = 0; i < NQ; i++) if (q[i].size() != 0) p = 1'b1;
      return p;
   endfunction

   task automatic drain(output int ncyc);
      ncyc = 0;
      while (pending() && ncyc < 2000) begin
         cycle();
         ncyc++;
      end
      chk("drain_budget_expired", 64'(ncyc >= 2000), 64'(0));
   endtask

   task automatic reset_pulse();
      rst_i = 1'b1;
      #1;
      for (int u = 0; u < 2; u++) begin
         chk($sformatf("u%0d rst grant", u), 64'(f_grant(u)), 64'(0));
         chk($sformatf("u%0d rst busy", u), 64'(f_busy(u)), 64'(0));
         chk($sformatf("u%0d rst tvalid", u), 64'(f_valid(u)), 64'(0));
         chk($sformatf("u%0d rst src_tready", u), 64'(f_rdy(u)), 64'(0));
         m_busy[u] = 1'b0;
         m_done[u] = 1'b0;
         m_ptr[u]  = 0;
      end
      for (int i = 0; i < NQ; i++) begin
         q[i].delete();
         s_valid[i] = 1'b0;
         s_word[i]  = '0;
      end
      @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nc, b0;
      n_assert = 0;
      n_fail   = 0;
      rst_i    = 1'b1;
      rand_gap = 1'b0;
      rdy_mode = 0;
      cyc      = 0;
      n_src[0] = 4;
      n_src[1] = 3;
      for (int u = 0; u < 2; u++) begin
         m_busy[u] = 1'b0; m_done[u] = 1'b0; m_owner[u] = 0; m_ptr[u] = 0;
         beats[u] = 0; dones[u] = 0; o_ready[u] = 1'b1;
      end
      for (int i = 0; i < NQ; i++) begin
         s_valid[i] = 1'b0; s_word[i] = '0; gap[i] = 1'b0;
      end

      @(negedge clk_i);
      #1;
      for (int u = 0; u < 2; u++) begin
         chk($sformatf("u%0d reset grant", u), 64'(f_grant(u)), 64'(0));
         chk($sformatf("u%0d reset busy", u), 64'(f_busy(u)), 64'(0));
         chk($sformatf("u%0d reset done", u), 64'(f_done(u)), 64'(0));
         chk($sformatf("u%0d reset tvalid", u), 64'(f_valid(u)), 64'(0));
         chk($sformatf("u%0d reset src_tready", u), 64'(f_rdy(u)), 64'(0));
      end
      @(negedge clk_i);
      rst_i = 1'b0;

      // All four sources hold a 2-word packet: order 0..3, one bubble per packet.
      for (int k = 0; k < 4; k++) add_pkt(0, k, 2, 32'h100 * 32'(k), 32'h1, 1'b0);
      drain(nc);
      chk("all4 cycles", 64'(nc), 64'(13));
      chk("all4 order", order_code(0), 64'h1234);
      order[0].delete();

      // Single 3-word packet on source 0.
      b0 = beats[0];
      nc = dones[0];
      add_pkt(0, 0, 3, 32'h11, 32'h11, 1'b0);
      begin
         int d0;
         d0 = nc;
         drain(nc);
         chk("single cycles", 64'(nc), 64'(5));
         chk("single done pulses", 64'(dones[0] - d0), 64'(1));
      end
      chk("single beats", 64'(beats[0] - b0), 64'(3));
      chk("single order", order_code(0), 64'h1);
      order[0].delete();

      // Source 2 finishes, then 1 and 3 compete: 3 wins, then 1.
      add_pkt(0, 2, 2, 32'h200, 32'h1, 1'b0);
      drain(nc);
      add_pkt(0, 1, 2, 32'h300, 32'h1, 1'b0);
      add_pkt(0, 3, 2, 32'h400, 32'h1, 1'b0);
      drain(nc);
      chk("fair order", order_code(0), 64'h342);
      order[0].delete();

      // Output back-pressure 1,0,0,1 with a competing non-owner.
      cyc = 0;
      rdy_mode = 1;
      add_pkt(0, 2, 4, 32'hA0, 32'h1, 1'b0);
      add_pkt(0, 0, 2, 32'hB0, 32'h1, 1'b0);
      b0 = beats[0];
      drain(nc);
      rdy_mode = 0;
      chk("bp beats", 64'(beats[0] - b0), 64'(6));
      chk("bp order", order_code(0), 64'h31);
      order[0].delete();

      // Reset after word 2 of a 5-word packet; arbitration restarts at 0.
      add_pkt(0, 3, 5, 32'hC0, 32'h1, 1'b0);
      b0 = beats[0];
      nc = 0;
      while (beats[0] < b0 + 2 && nc < 50) begin
         cycle();
         nc++;
      end
      chk("rst setup beats", 64'(beats[0] - b0), 64'(2));
      chk("rst setup busy", 64'(busy0), 64'(1));
      reset_pulse();
      add_pkt(0, 1, 2, 32'hD0, 32'h1, 1'b0);
      add_pkt(0, 0, 2, 32'hE0, 32'h1, 1'b0);
      drain(nc);
      chk("post-rst order", order_code(0), 64'h12);
      order[0].delete();

      // Three-input instance: set pointer to 2, then 2 and 0 compete -> 2 then wrap to 0.
      add_pkt(1, 1, 2, 32'h500, 32'h1, 1'b0);
      drain(nc);
      add_pkt(1, 2, 3, 32'h600, 32'h1, 1'b0);
      add_pkt(1, 0, 2, 32'h700, 32'h1, 1'b0);
      drain(nc);
      chk("n3 order", order_code(1), 64'h231);
      order[1].delete();

      // Random traffic with source gaps and random output back-pressure.
      rand_gap = 1'b1;
      rdy_mode = 2;
      for (int c = 0; c < 400; c++) begin
         for (int u = 0; u < 2; u++) begin
            if ($urandom_range(0, 5) == 0) begin
               int k;
               k = $urandom_range(0, n_src[u] - 1);
               if (q[u*4+k].size() < 8) add_pkt(u, k, $urandom_range(1, 4), 32'h0, 32'h0, 1'b1);
            end
         end
         cycle();
      end
      drain(nc);
      rand_gap = 1'b0;
      rdy_mode = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
